grf_hazard_scoreboard: RTL and testbench
========================================

Name: grf_hazard_scoreboard

Overview:
- Decode-stage hazard controller for the 5-stage MIPS pipeline (D/E/M/W) that owns the GRF read ports.
- Tracks in-flight GRF writers per register, plus the busy window of the mult/div unit.
- Generates a D-stage stall and D-stage forward selects for both read ports, so the GRF write-through bypass covers the W case.

Parameters:
- MULT_CYC, 5, busy cycles loaded on mult/multu start
- DIV_CYC, 10, busy cycles loaded on div/divu start
- CNT_W, 4, width of md busy counter; must hold DIV_CYC

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- d_valid  in  1  valid instruction in D
- d_rs  in  5  rs read address (GRF A1)
- d_rt  in  5  rt read address (GRF A2)
- d_rs_used  in  1  instruction reads rs
- d_rt_used  in  1  instruction reads rt
- d_rs_tuse  in  2  cycles after D until rs is needed (0 = D, 1 = E, 2 = M)
- d_rt_tuse  in  2  same for rt
- d_we  in  1  instruction writes GRF
- d_dst  in  5  destination register
- d_tnew  in  2  cycles after entering E until the result exists in a pipeline register
- d_md_use  in  1  instruction touches mult/div (mult/div/mfhi/mflo/mthi/mtlo)
- d_md_start  in  1  instruction starts mult/div
- d_md_is_div  in  1  start is a divide
- stall  out  1  freeze PC/D, bubble into E
- fwd_rs_sel  out  2  D-stage rs source: 0 GRF (incl. bypass), 1 from E, 2 from M
- fwd_rt_sel  out  2  same for rt
- md_busy  out  1  mult/div counter nonzero

Behaviour:
- issue = d_valid & ~stall.
- Per-register entry r (1..31): busy, pos[1:0] (1 = E, 2 = M, 3 = W), cnt[1:0].
- On issue with d_we and d_dst != 0, the next cycle holds entry[d_dst] = {busy 1, pos 1, cnt d_tnew}.
- Every other busy entry advances each cycle:
  - cnt saturating-decrements to 0.
  - pos increments.
  - An entry with pos 3 clears (written to GRF at end of W).
- Issue to a register on the same cycle it retires or advances: the issue load wins (newest writer).
- Register 0 is never tracked; a source of 0 never stalls and selects 0.
- Per source s (rs/rt), with used_s and entry e = entry[addr_s]:
  - hz_s = used_s & e.busy & (e.cnt > tuse_s).
  - sel_s = 1 if e.busy & e.cnt == 0 & pos == 1.
  - sel_s = 2 if e.busy & e.cnt == 0 & pos == 2.
  - sel_s = 0 otherwise.
  - Pos 3 relies on the GRF write-through bypass.
- md_cnt:
  - On issue with d_md_start, loads MULT_CYC or DIV_CYC.
  - Otherwise decrements to 0.
  - md_busy = (md_cnt != 0).
  - hz_md = d_valid & d_md_use & md_busy.
- stall = d_valid & (hz_rs | hz_rt | hz_md).
  - stall and fwd selects are combinational from state and D inputs, evaluated in the same cycle.
- During stall, no entry loads and existing entries keep advancing (a bubble enters E).
- Reset: all entries clear, md_cnt 0; stall 0, fwd selects 0, md_busy 0 from the cycle after reset is sampled.
  - Reset mid-stall or mid-divide aborts immediately.
- d_valid low: stall 0, no issue.

Decomposition:
- Shared package: FWD_GRF = 0, FWD_E = 1, FWD_M = 2; POS_E / POS_M / POS_W encodings; TUSE/TNEW widths.
- One sub-module, grf_sb_entry, is natural: busy/pos/cnt register with load/advance/clear, instantiated 31 times.
- The top-level module holds the md counter and the compare/stall logic.

Test Plan:
- Load-use, ALU consumer: lw $1 (tnew 2) issues at cycle 0; addu $2,$1,$3 (tuse 1) at cycle 1 → stall=1 at cycle 1 only; issues at cycle 2 with fwd_rs_sel 0.
- Load-use, branch consumer: lw $1 (tnew 2) then beq $1,$0 (tuse 0) → stall at cycles 1 and 2; cycle 3: stall 0, fwd_rs_sel 0 (W via GRF bypass).
- ALU-to-branch: addu $3 (tnew 1) then beq $3,$4 → stall at cycle 1; cycle 2: stall 0, fwd_rs_sel 2. lui $5 (tnew 0) then beq $5 → no stall, fwd_rs_sel 1.
- Register 0 and newest-writer: lw $0 then addu using $0 → no stall, sel 0. addu $6 (tnew 1) then lw $6 (tnew 2) then a $6 consumer (tuse 1) → hazard is computed from the lw entry.
- Mult/div: mult issues, then mflo follows → md_busy high 5 cycles; mflo stalls until md_cnt hits 0. div → 10 cycles.
- Reset mid-operation: assert reset during a div stall → next cycle stall 0, md_busy 0, all selects 0; a previously hazarding consumer issues without stalling.

Source files
------------

// File: rtl/grf_hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// grf_hazard_scoreboard_pkg
// Shared types for the decode-stage GRF hazard scoreboard: forward-select
// codes, pipeline-position encoding of an in-flight writer, the per-register
// scoreboard entry record and the helper that maps an entry to a forward select.
// ----------------------------------------------------------------------------
package grf_hazard_scoreboard_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned NREG   = 32;
   localparam int unsigned TUSE_W = 2;
   localparam int unsigned TNEW_W = 2;

   typedef logic [TUSE_W-1:0] tuse_t;
   typedef logic [TNEW_W-1:0] tnew_t;
   typedef logic [REG_W-1:0]  reg_t;

   typedef enum logic [1:0] {
      FWD_GRF = 2'd0,
      FWD_E   = 2'd1,
      FWD_M   = 2'd2
   } fwd_sel_e;

   typedef enum logic [1:0] {
      POS_IDLE = 2'd0,
      POS_E    = 2'd1,
      POS_M    = 2'd2,
      POS_W    = 2'd3
   } pos_e;

   typedef struct packed {
      logic  busy;
      pos_e  pos;
      tnew_t cnt;
   } sb_entry_t;

   // A result is forwardable once its countdown has expired; a writer in W is
   // served by the GRF write-through bypass, so it maps to FWD_GRF.
   function automatic fwd_sel_e fwd_sel(input sb_entry_t e);
      fwd_sel_e sel;
      sel = FWD_GRF;
      if (e.busy && (e.cnt == '0)) begin
         case (e.pos)
            POS_E:   sel = FWD_E;
            POS_M:   sel = FWD_M;
            default: sel = FWD_GRF;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/grf_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// grf_hazard_scoreboard_if
// D-stage instruction descriptor into the scoreboard and the stall / forward
// select / mult-div busy indications back to the pipeline.
//   master : decode logic (drives d_*, receives stall/fwd/md_busy)
//   slave  : the scoreboard
// ----------------------------------------------------------------------------
interface grf_hazard_scoreboard_if;
   import grf_hazard_scoreboard_pkg::*;

   logic        d_valid;
   reg_t        d_rs;
   reg_t        d_rt;
   logic        d_rs_used;
   logic        d_rt_used;
   tuse_t       d_rs_tuse;
   tuse_t       d_rt_tuse;
   logic        d_we;
   reg_t        d_dst;
   tnew_t       d_tnew;
   logic        d_md_use;
   logic        d_md_start;
   logic        d_md_is_div;
   logic        stall;
   logic [1:0]  fwd_rs_sel;
   logic [1:0]  fwd_rt_sel;
   logic        md_busy;

   modport master (
      output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
             d_we, d_dst, d_tnew, d_md_use, d_md_start, d_md_is_div,
      input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
             d_we, d_dst, d_tnew, d_md_use, d_md_start, d_md_is_div,
      output stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );

endinterface

// File: rtl/grf_hazard_scoreboard_entry.sv
// ----------------------------------------------------------------------------
// grf_sb_entry
// One scoreboard entry: tracks the newest in-flight writer of one register.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : writer issues this cycle (overrides advance/retire)
//   tnew_i     : result latency of the issuing writer
//   ent_o      : current {busy, pos, cnt}
// ----------------------------------------------------------------------------
module grf_sb_entry
   import grf_hazard_scoreboard_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      load_i,
   input  tnew_t     tnew_i,
   output sb_entry_t ent_o
);

   sb_entry_t ent_q, ent_d;

   always_comb begin
      ent_d = ent_q;
      if (load_i) begin
         ent_d.busy = 1'b1;
         ent_d.pos  = POS_E;
         ent_d.cnt  = tnew_i;
      end else if (ent_q.busy) begin
         ent_d.cnt = (ent_q.cnt == '0) ? '0 : ent_q.cnt - TNEW_W'(1);
         case (ent_q.pos)
            POS_E:   ent_d.pos = POS_M;
            POS_M:   ent_d.pos = POS_W;
            default: ent_d   = '0;   // leaves W: value now in the GRF
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ent_q <= '0;
      else       ent_q <= ent_d;
   end

   assign ent_o = ent_q;

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// grf_hazard_scoreboard
// Decode-stage hazard controller: per-register writer tracking, mult/div busy
// window, D-stage stall and forward selects for the two GRF read ports.
//   clk, reset : clock, synchronous active-high reset
//   sb (slave) : D-stage descriptor in; stall, fwd_rs_sel, fwd_rt_sel,
//                md_busy out (all outputs combinational from state + D inputs)
// ----------------------------------------------------------------------------
module grf_hazard_scoreboard
   import grf_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10,
   parameter int unsigned CNT_W    = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   grf_hazard_scoreboard_if.slave sb
);

   sb_entry_t        ents [NREG];
   sb_entry_t        e_rs, e_rt;
   logic             hz_rs, hz_rt, hz_md;
   logic             stall_w, issue;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

   // Register 0 is never tracked, so a $0 source always reads as idle.
   assign ents[0] = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_ent
      logic load;
      assign load = issue & sb.d_we & (sb.d_dst == REG_W'(r));
      grf_sb_entry u_ent (
         .clk    (clk),
         .reset  (reset),
         .load_i (load),
         .tnew_i (sb.d_tnew),
         .ent_o  (ents[r])
      );
   end

   always_comb begin
      e_rs    = ents[sb.d_rs];
      e_rt    = ents[sb.d_rt];
      hz_rs   = sb.d_rs_used & e_rs.busy & (e_rs.cnt > sb.d_rs_tuse);
      hz_rt   = sb.d_rt_used & e_rt.busy & (e_rt.cnt > sb.d_rt_tuse);
      hz_md   = sb.d_valid & sb.d_md_use & (md_cnt_q != '0);
      stall_w = sb.d_valid & (hz_rs | hz_rt | hz_md);
      issue   = sb.d_valid & ~stall_w;
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (issue & sb.d_md_start)
         md_cnt_d = sb.d_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) md_cnt_q <= '0;
      else       md_cnt_q <= md_cnt_d;
   end

   assign sb.stall      = stall_w;
   assign sb.fwd_rs_sel = fwd_sel(e_rs);
   assign sb.fwd_rt_sel = fwd_sel(e_rt);
   assign sb.md_busy    = (md_cnt_q != '0);

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
module tb_grf_hazard_scoreboard;
   import grf_hazard_scoreboard_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   grf_hazard_scoreboard_if sb_if ();

   grf_hazard_scoreboard #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs, rt;
      logic       rs_used, rt_used;
      logic [1:0] rs_tuse, rt_tuse;
      logic       we;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       md_use, md_start, md_is_div;
   } dop_t;

   typedef struct {
      dop_t op;
      bit   rst;
      int   st, rs, rt, md;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model: each register remembers the issue cycle and latency of
   // its newest writer; the mult/div window is an issue cycle plus a length.
   int cyc = 0;
   bit wv [32];
   int wc [32];
   int wt [32];
   bit mdv = 0;
   int mdt0 = 0, mdn = 0;

   function automatic dop_t op(input int rs, input int tus, input int rt, input int tut,
                               input int we, input int dst, input int tnew);
      dop_t o;
      o = '0;
      o.valid   = 1'b1;
      o.rs      = 5'(rs);
      o.rs_used = (tus >= 0);
      o.rs_tuse = (tus < 0) ? 2'd0 : 2'(tus);
      o.rt      = 5'(rt);
      o.rt_used = (tut >= 0);
      o.rt_tuse = (tut < 0) ? 2'd0 : 2'(tut);
      o.we      = (we != 0);
      o.dst     = 5'(dst);
      o.tnew    = 2'(tnew);
      return o;
   endfunction

   function automatic dop_t mdop(input bit use_, input bit start, input bit dv,
                                 input int we, input int dst);
      dop_t o;
      o = op(0, -1, 0, -1, we, dst, 1);
      o.md_use = use_;  o.md_start = start;  o.md_is_div = dv;
      return o;
   endfunction

   function automatic vec_t v(input dop_t o, input bit rst, input int st,
                              input int rs, input int rt, input int md);
      vec_t x;
      x.op = o; x.rst = rst; x.st = st; x.rs = rs; x.rt = rt; x.md = md;
      return x;
   endfunction

   function automatic void model_src(input logic [4:0] a, input logic used,
                                     input logic [1:0] tuse, output bit hz, output int sel);
      int age, cnt;
      hz = 0; sel = 0;
      if (a != 0 && wv[a]) begin
         age = cyc - wc[a];
         if (age >= 1 && age <= 3) begin
            cnt = wt[a] - (age - 1);
            if (cnt < 0) cnt = 0;
            hz = used && (cnt > int'(tuse));
            if (cnt == 0 && age == 1) sel = 1;
            if (cnt == 0 && age == 2) sel = 2;
         end
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input dop_t o, input bit rst, input bit tab, input int est,
                       input int ers, input int ert, input int emd, input string nm);
      bit hs, ht, mmd, mst;
      int ss, st;
      @(negedge clk);
      reset = rst;
      sb_if.d_valid   = o.valid;    sb_if.d_rs        = o.rs;
      sb_if.d_rt      = o.rt;       sb_if.d_rs_used   = o.rs_used;
      sb_if.d_rt_used = o.rt_used;  sb_if.d_rs_tuse   = o.rs_tuse;
      sb_if.d_rt_tuse = o.rt_tuse;  sb_if.d_we        = o.we;
      sb_if.d_dst     = o.dst;      sb_if.d_tnew      = o.tnew;
      sb_if.d_md_use  = o.md_use;   sb_if.d_md_start  = o.md_start;
      sb_if.d_md_is_div = o.md_is_div;
      #1;
      model_src(o.rs, o.rs_used, o.rs_tuse, hs, ss);
      model_src(o.rt, o.rt_used, o.rt_tuse, ht, st);
      mmd = mdv && (cyc > mdt0) && (cyc - mdt0 <= mdn);
      mst = o.valid && (hs || ht || (o.md_use && mmd));
      if (!rst) begin
         chk({nm, ":model_stall"},   int'(sb_if.stall),      int'(mst));
         chk({nm, ":model_rs_sel"},  int'(sb_if.fwd_rs_sel), ss);
         chk({nm, ":model_rt_sel"},  int'(sb_if.fwd_rt_sel), st);
         chk({nm, ":model_md_busy"}, int'(sb_if.md_busy),    int'(mmd));
      end
      if (tab) begin
         chk({nm, ":stall"},   int'(sb_if.stall),      est);
         chk({nm, ":rs_sel"},  int'(sb_if.fwd_rs_sel), ers);
         chk({nm, ":rt_sel"},  int'(sb_if.fwd_rt_sel), ert);
         chk({nm, ":md_busy"}, int'(sb_if.md_busy),    emd);
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) wv[i] = 0;
         mdv = 0;
      end else if (o.valid && !mst) begin
         if (o.we && o.dst != 0) begin
            wv[o.dst] = 1; wc[o.dst] = cyc; wt[o.dst] = int'(o.tnew);
         end
         if (o.md_start) begin
            mdv = 1; mdt0 = cyc; mdn = o.md_is_div ? DIV_N : MULT_N;
         end
      end
      cyc++;
   endtask

   initial begin
      vec_t tab[$];
      dop_t nop, mflo, cons;
      nop  = '0;
      mflo = mdop(1, 0, 0, 1, 9);

      // load-use, ALU consumer
      tab.push_back(v(nop, 1, 0, 0, 0, 0));
      tab.push_back(v(op(2, 1, 0, -1, 1, 1, 2), 0, 0, 0, 0, 0));
      tab.push_back(v(op(1, 1, 3, 1, 1, 2, 1), 0, 1, 0, 0, 0));
      tab.push_back(v(op(1, 1, 3, 1, 1, 2, 1), 0, 0, 0, 0, 0));
      tab.push_back(v(nop, 0, 0, 0, 0, 0));
      // load-use, branch consumer
      tab.push_back(v(nop, 1, 0, 0, 0, 0));
      tab.push_back(v(op(0, -1, 0, -1, 1, 1, 2), 0, 0, 0, 0, 0));
      tab.push_back(v(op(1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0));
      tab.push_back(v(op(1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0));
      tab.push_back(v(op(1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
      // ALU-to-branch, then lui-to-branch
      tab.push_back(v(nop, 1, 0, 0, 0, 0));
      tab.push_back(v(op(5, 1, 6, 1, 1, 3, 1), 0, 0, 0, 0, 0));
      tab.push_back(v(op(3, 0, 4, 0, 0, 0, 0), 0, 1, 0, 0, 0));
      tab.push_back(v(op(3, 0, 4, 0, 0, 0, 0), 0, 0, 2, 0, 0));
      tab.push_back(v(op(0, -1, 0, -1, 1, 5, 0), 0, 0, 0, 0, 0));
      tab.push_back(v(op(5, 0, 3, 0, 0, 0, 0), 0, 0, 1, 0, 0));
      // $0 writer is ignored; newest writer of $6 decides
      tab.push_back(v(nop, 1, 0, 0, 0, 0));
      tab.push_back(v(op(0, -1, 0, -1, 1, 0, 2), 0, 0, 0, 0, 0));
      tab.push_back(v(op(0, 1, 0, 1, 1, 7, 1), 0, 0, 0, 0, 0));
      tab.push_back(v(op(0, -1, 0, -1, 1, 6, 1), 0, 0, 0, 0, 0));
      tab.push_back(v(op(0, -1, 0, -1, 1, 6, 2), 0, 0, 0, 0, 0));
      tab.push_back(v(op(6, 1, 0, -1, 1, 8, 1), 0, 1, 0, 0, 0));
      tab.push_back(v(op(6, 1, 0, -1, 1, 8, 1), 0, 0, 0, 0, 0));
      // mult then mflo: busy exactly MULT_N cycles
      tab.push_back(v(nop, 1, 0, 0, 0, 0));
      tab.push_back(v(mdop(1, 1, 0, 0, 0), 0, 0, 0, 0, 0));
      for (int i = 0; i < MULT_N; i++) tab.push_back(v(mflo, 0, 1, 0, 0, 1));
      tab.push_back(v(mflo, 0, 0, 0, 0, 0));

      foreach (tab[i])
         step(tab[i].op, tab[i].rst, !tab[i].rst, tab[i].st, tab[i].rs, tab[i].rt,
              tab[i].md, $sformatf("vec%0d", i));

      // divide: busy exactly DIV_N cycles
      step(nop, 1, 0, 0, 0, 0, 0, "div_rst");
      step(mdop(1, 1, 1, 0, 0), 0, 1, 0, 0, 0, 0, "div_start");
      for (int i = 0; i < DIV_N; i++) step(mflo, 0, 1, 1, 0, 0, 1, "div_wait");
      step(mflo, 0, 1, 0, 0, 0, 0, "div_done");

      // reset during a divide stall with a pending load-use hazard
      step(nop, 1, 0, 0, 0, 0, 0, "mid_rst0");
      step(mdop(1, 1, 1, 0, 0), 0, 1, 0, 0, 0, 0, "mid_div");
      step(op(0, -1, 0, -1, 1, 1, 2), 0, 1, 0, 0, 0, 1, "mid_lw");
      cons = op(1, 0, 0, -1, 1, 10, 1);
      cons.md_use = 1'b1;
      step(cons, 0, 1, 1, 0, 0, 1, "mid_stall");
      step(cons, 1, 0, 0, 0, 0, 0, "mid_reset");
      step(cons, 0, 1, 0, 0, 0, 0, "after_rst");
      step(nop, 0, 1, 0, 0, 0, 0, "after_rst_nop");

      // randomized traffic, small register range to force collisions
      for (int i = 0; i < 3000; i++) begin
         dop_t o;
         bit   rst;
         o = '0;
         o.valid     = ($urandom_range(0, 3) != 0);
         o.rs        = 5'($urandom_range(0, 7));
         o.rt        = 5'($urandom_range(0, 7));
         o.rs_used   = 1'($urandom_range(0, 1));
         o.rt_used   = 1'($urandom_range(0, 1));
         o.rs_tuse   = 2'($urandom_range(0, 2));
         o.rt_tuse   = 2'($urandom_range(0, 2));
         o.we        = 1'($urandom_range(0, 1));
         o.dst       = 5'($urandom_range(0, 7));
         o.tnew      = 2'($urandom_range(0, 2));
         o.md_use    = ($urandom_range(0, 7) == 0);
         o.md_start  = o.md_use && ($urandom_range(0, 1) == 1);
         o.md_is_div = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 99) == 0);
         step(o, rst, 0, 0, 0, 0, 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
